// File: rtl/sample_sched.sv
// sample_sched: resource-shared, multi-cycle version of the sel-driven
// arithmetic kernel. One add/subtract unit and one 8x8 multiplier are
// time-multiplexed across the OP1, OP2 and FIN steps by a small FSM.
//
// Optional build macro: SAMPLE_SCHED_MULT_PIPE_EN
//   When defined, a register is placed on the multiplier output. Multiply
//   operations (sel1/sel2) then spend one extra cycle in MWAIT.
//   When undefined, the multiplier is single-cycle and MWAIT is unreachable.

module sample_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  sel,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  // MWAIT only becomes reachable when the multiplier output is registered.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OP1   = 3'd1,
    OP2   = 3'd2,
    FIN   = 3'd3,
    MWAIT = 3'd4
  } state_t;

  localparam logic [15:0] CONST_X = 16'd10;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  in1_q, in1_d;
  logic [7:0]  in2_q, in2_d;
  logic [7:0]  in3_q, in3_d;
  logic [15:0] tmp_q, tmp_d;
  logic [15:0] y_q, y_d;
  logic [15:0] out_q, out_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
`ifdef SAMPLE_SCHED_MULT_PIPE_EN
  logic [15:0] mult_q, mult_d;
`endif

  // Operation decode of the captured select code.
  logic op1IsMul;
  logic op1IsSub;
  logic op2IsSub;
  logic op2UsesIn1;

  // Shared arithmetic resources and their operand steering.
  logic [15:0] addA;
  logic [15:0] addB;
  logic        addSub;
  logic [15:0] addRes;
  logic [7:0]  mulA;
  logic [7:0]  mulB;
  logic [15:0] mulRes;

  // Decode which flavour of OP1/OP2 the captured sel requests.
  always_comb begin
    op1IsMul   = 1'b0;
    op1IsSub   = 1'b0;
    op2IsSub   = 1'b0;
    op2UsesIn1 = 1'b0;
    case (sel_q)
      3'd0: begin
        op1IsMul = 1'b0;
        op2IsSub = 1'b0;
      end
      3'd1: begin
        op1IsMul   = 1'b1;
        op2UsesIn1 = 1'b1;
      end
      3'd2: begin
        op1IsMul = 1'b1;
      end
      3'd3: begin
        op1IsSub = 1'b1;
        op2IsSub = 1'b1;
      end
      3'd4: begin
        op1IsSub = 1'b1;
      end
      default: begin
        op2IsSub = 1'b1;
      end
    endcase
  end

  // The single add/subtract unit, modulo 2^16.
  always_comb begin
    if (addSub) begin
      addRes = addA - addB;
    end else begin
      addRes = addA + addB;
    end
  end

  // The single 8x8 multiplier producing a full 16-bit product.
  always_comb begin
    mulRes = 16'(mulA) * 16'(mulB);
  end

  // Next-state logic plus operand steering for the shared units.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    in3_d   = in3_q;
    tmp_d   = tmp_q;
    y_d     = y_q;
    out_d   = out_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SAMPLE_SCHED_MULT_PIPE_EN
    mult_d  = mult_q;
`endif
    addA    = 16'd0;
    addB    = 16'd0;
    addSub  = 1'b0;
    mulA    = 8'd0;
    mulB    = 8'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = sel;
          in1_d   = in1;
          in2_d   = in2;
          in3_d   = in3;
          busy_d  = 1'b1;
          state_d = OP1;
        end
      end

      OP1: begin
        if (op1IsMul) begin
          // sel1 multiplies in2*in3, sel2 multiplies in1*in2.
          if (sel_q == 3'd1) begin
            mulA = in2_q;
            mulB = in3_q;
          end else begin
            mulA = in1_q;
            mulB = in2_q;
          end
`ifdef SAMPLE_SCHED_MULT_PIPE_EN
          mult_d  = mulRes;
          state_d = MWAIT;
`else
          tmp_d   = mulRes;
          state_d = OP2;
`endif
        end else begin
          // 9-bit add/sub: keep the low 9 bits, zero-extend to 16.
          addA    = {8'd0, in1_q};
          addB    = {8'd0, in2_q};
          addSub  = op1IsSub;
          tmp_d   = {7'd0, addRes[8:0]};
          state_d = OP2;
        end
      end

`ifdef SAMPLE_SCHED_MULT_PIPE_EN
      MWAIT: begin
        tmp_d   = mult_q;
        state_d = OP2;
      end
`endif

      OP2: begin
        addA    = tmp_q;
        addB    = op2UsesIn1 ? {8'd0, in1_q} : {8'd0, in3_q};
        addSub  = op2IsSub;
        y_d     = addRes;
        state_d = FIN;
      end

      FIN: begin
        addA    = CONST_X;
        addB    = y_q;
        addSub  = 1'b0;
        out_d   = addRes;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= 3'd0;
      in1_q  <= 8'd0;
      in2_q  <= 8'd0;
      in3_q  <= 8'd0;
      tmp_q  <= 16'd0;
      y_q    <= 16'd0;
      out_q  <= 16'd0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      in1_q  <= in1_d;
      in2_q  <= in2_d;
      in3_q  <= in3_d;
      tmp_q  <= tmp_d;
      y_q    <= y_d;
      out_q  <= out_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

`ifdef SAMPLE_SCHED_MULT_PIPE_EN
  // Pipeline register on the multiplier output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mult_q <= 16'd0;
    end else begin
      mult_q <= mult_d;
    end
  end
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_sample_sched.sv
// tb_sample_sched: directed bench for sample_sched. Each scenario task drives
// a transaction and compares against hand-computed results.

module tb_sample_sched;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  sel   = 3'd0;
  logic [7:0]  in1   = 8'd0;
  logic [7:0]  in2   = 8'd0;
  logic [7:0]  in3   = 8'd0;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int errors = 0;
  int checks = 0;

`ifdef SAMPLE_SCHED_MULT_PIPE_EN
  localparam int LAT_MUL = 4;
`else
  localparam int LAT_MUL = 3;
`endif

  sample_sched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sel  (sel),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle start pulse; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] s, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] c);
    sel   = s;
    in1   = a;
    in2   = b;
    in3   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done (bounded); also count cycles seen with busy high.
  task automatic waitDone(output int lat, output int busyCycles);
    lat = -1;
    busyCycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy === 1'b1) busyCycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b out=%0d, required busy=0 done=0 out=0",
               busy, done, out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sel0_sel1();
    int lat;
    int bc;
    applyStimulus(3'd0, 8'd1, 8'd2, 8'd3);
    waitDone(lat, bc);
    checks++;
    if (lat !== 3 || bc !== 3) begin
      errors++;
      $display("[TB] FAIL sel0_timing: latency=%0d busy_cycles=%0d, required 3 and 3", lat, bc);
    end
    checks++;
    if (out !== 16'd16 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sel0_out: out=%0d busy=%b, required out=16 busy=0", out, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || out !== 16'd16) begin
      errors++;
      $display("[TB] FAIL done_pulse_hold: done=%b out=%0d, required done=0 out=16", done, out);
    end

    applyStimulus(3'd1, 8'd5, 8'd200, 8'd100);
    waitDone(lat, bc);
    checks++;
    if (lat !== LAT_MUL || out !== 16'd20015) begin
      errors++;
      $display("[TB] FAIL sel1: latency=%0d out=%0d, required latency=%0d out=20015",
               lat, out, LAT_MUL);
    end
    tick();
  endtask

  task automatic test_sel2_sel3();
    int lat;
    int bc;
    applyStimulus(3'd2, 8'd255, 8'd255, 8'd255);
    waitDone(lat, bc);
    checks++;
    if (lat !== LAT_MUL || out !== 16'd65290) begin
      errors++;
      $display("[TB] FAIL sel2_max: latency=%0d out=%0d, required latency=%0d out=65290",
               lat, out, LAT_MUL);
    end
    tick();
    applyStimulus(3'd3, 8'd3, 8'd5, 8'd1);
    waitDone(lat, bc);
    checks++;
    if (lat !== 3 || out !== 16'd519) begin
      errors++;
      $display("[TB] FAIL sel3_wrap: latency=%0d out=%0d, required latency=3 out=519", lat, out);
    end
    tick();
  endtask

  task automatic test_sel4_sel7();
    int lat;
    int bc;
    applyStimulus(3'd4, 8'd200, 8'd100, 8'd7);
    waitDone(lat, bc);
    checks++;
    if (lat !== 3 || out !== 16'd117) begin
      errors++;
      $display("[TB] FAIL sel4: latency=%0d out=%0d, required latency=3 out=117", lat, out);
    end
    tick();
    applyStimulus(3'd7, 8'd255, 8'd255, 8'd0);
    waitDone(lat, bc);
    checks++;
    if (lat !== 3 || out !== 16'd520) begin
      errors++;
      $display("[TB] FAIL sel7_default: latency=%0d out=%0d, required latency=3 out=520", lat, out);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    int bc;
    int extraDone;
    applyStimulus(3'd0, 8'd1, 8'd2, 8'd3);
    // DUT now in OP1; a second request here must be dropped entirely.
    sel   = 3'd2;
    in1   = 8'd255;
    in2   = 8'd255;
    in3   = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(lat, bc);
    checks++;
    if (lat !== 2 || out !== 16'd16) begin
      errors++;
      $display("[TB] FAIL ignore_start: remaining_latency=%0d out=%0d, required 2 and out=16",
               lat, out);
    end
    extraDone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) extraDone++;
    end
    checks++;
    if (extraDone !== 0 || out !== 16'd16) begin
      errors++;
      $display("[TB] FAIL not_queued: extra_done=%0d out=%0d, required 0 and out=16",
               extraDone, out);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    applyStimulus(3'd4, 8'd200, 8'd100, 8'd7);
    waitDone(lat, bc);
    checks++;
    if (done !== 1'b1 || out !== 16'd117) begin
      errors++;
      $display("[TB] FAIL b2b_first: done=%b out=%0d, required done=1 out=117", done, out);
    end
    // Start issued while done is high: accepted at the next edge.
    applyStimulus(3'd0, 8'd10, 8'd20, 8'd30);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    waitDone(lat, bc);
    checks++;
    if (lat !== 3 || out !== 16'd70) begin
      errors++;
      $display("[TB] FAIL b2b_second: latency=%0d out=%0d, required latency=3 out=70", lat, out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    int strayDone;
    applyStimulus(3'd0, 8'd1, 8'd2, 8'd3);
    tick();
    // DUT is in OP2; reset lands on the next edge.
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: busy=%b out=%0d done=%b, required busy=0 out=0 done=0",
               busy, out, done);
    end
    rst_n = 1'b1;
    strayDone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) strayDone++;
    end
    checks++;
    if (strayDone !== 0 || out !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_drop: stray_done=%0d out=%0d, required 0 and out=0",
               strayDone, out);
    end
    applyStimulus(3'd3, 8'd3, 8'd5, 8'd1);
    waitDone(lat, bc);
    checks++;
    if (lat !== 3 || bc !== 3 || out !== 16'd519) begin
      errors++;
      $display("[TB] FAIL after_reset: latency=%0d busy_cycles=%0d out=%0d, required 3, 3, 519",
               lat, bc, out);
    end
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_sel0_sel1();
    test_sel2_sel3();
    test_sel4_sel7();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_sched.md
# sample_sched

Multi-cycle scheduled implementation of the `sel`-driven arithmetic kernel. It uses exactly one shared add/subtract unit and one shared 8x8 multiplier, sequenced by an FSM, in place of a fully parallel combinational datapath. It sits between a requester issuing `start`/`done` transactions and the downstream consumer of `out`. It is the resource-shared, clocked counterpart of the unscheduled kernel.

## Interface
- Parameters: none (widths fixed: operands 8 b, result 16 b, constant X = 16'd10).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `sel` input 3: operation select, captured with `start`.
- `in1`, `in2`, `in3` input 8 each: unsigned operands, captured with `start`.
- `busy` output 1: high while a transaction is in flight.
- `done` output 1: one-cycle pulse, `out` valid and updated.
- `out` output 16: result register, holds value until the next `done`.

## Operation
- States: IDLE, OP1, OP2, FIN (plus MWAIT under macro).
- IDLE with `start`=1: register `sel`/`in1..3`, go to OP1. Otherwise stay.
- OP1: first step through the shared unit into `tmp`:
  - sel0: in1+in2
  - sel1: in2*in3
  - sel2: in1*in2
  - sel3: in1-in2
  - sel4: in1-in2
  - sel5..7: in1+in2
- OP2: `y` = sel0: tmp+in3; sel1: in1+tmp; sel2: tmp+in3; sel3: tmp-in3; sel4: tmp+in3; sel5..7: tmp-in3.
- FIN: `out` <= 16'd10 + y; `done` <= 1; go to IDLE.
- Width rules:
  - Add/sub results in OP1 are 9 b, wrapped modulo 512, then zero-extended to 16 b.
  - Multiply results are full 16 b.
  - OP2 and FIN are modulo 2^16, with no saturation or flags.
- Only one add/sub operation and one multiply occur per cycle. The final +10 reuses the add/sub unit.
- `start` in any non-IDLE state is ignored and not queued. Operands are not re-sampled mid-transaction.
- Reset (`rst_n`=0 at an edge), including mid-transaction:
  - State goes to IDLE.
  - `out`=0, `done`=0, `busy`=0; `tmp`/`y` cleared.
  - The in-flight transaction is dropped and produces no `done`.

## Timing
- Edge 0 accepts `start`. OP1 at edge 1, OP2 at edge 2, FIN at edge 3.
- `done`=1 and the new `out` are visible after edge 3, giving a latency of 3 cycles from acceptance.
- `busy`=1 from after edge 0 until edge 3. It drops in the same cycle `done` rises.
- Back-to-back: `start` high while `done` is high is accepted, giving one result every 4 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SAMPLE_SCHED_MULT_PIPE_EN` defined:
  - A register is inserted on the multiplier output.
  - For sel1/sel2, OP1 goes to MWAIT for one cycle before OP2, giving `done` latency 4 cycles and 5 cycles per transaction.
  - Other sel values are unchanged, at 3 cycles.
- Undefined: the multiplier is single-cycle, MWAIT is never entered, and all sel values have 3-cycle latency.

## Test plan
- Sequential sel0 and sel1 transactions:
  - sel0, in=1/2/3, `start` pulse -> `busy` 3 cycles, `done` one cycle, `out`=16.
  - sel1, in1=5, in2=200, in3=100 -> `out`=20015 (3 cycles, or 4 with macro).
- sel2, in1=in2=in3=255 -> y=65280, `out`=65290. Then sel3, in1=3, in2=5, in3=1 -> tmp=510 (9-bit wrap), `out`=519.
- sel4, 200/100/7 -> `out`=117. Default sel7, 255/255/0 -> tmp=510, `out`=520.
- Re-assert `start` with different operands during OP1 -> ignored, first result only. Assert `start` during `done` with sel0 10/20/30 -> accepted, next `out`=70 exactly 4 cycles later.
- Drop `rst_n` in OP2 -> next cycle `busy`=0, `out`=0, no `done`. A new transaction then completes normally.
